// File: rtl/spy_fifo_reader.sv
// Read-domain consumer of the spy buffer async FIFO: re-presents FIFO words as a
// valid/ready stream via a 2-entry register buffer, with enable gating, flush and counters.
module spy_fifo_reader #(
    parameter int DSIZE      = 8,
    parameter int CNTW       = 32,
    parameter int FLUSH_IDLE = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic             en,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             flushing,
    output logic [CNTW-1:0]  words_read,
    output logic [CNTW-1:0]  words_dropped
);

    localparam int IW = $clog2(FLUSH_IDLE + 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t           r_state;
    logic [1:0]       r_count;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [IW-1:0]    r_idle;
    logic [CNTW-1:0]  r_rd_cnt;
    logic [CNTW-1:0]  r_drop_cnt;

    logic             w_rinc;
    logic             w_pop;
    logic [IW-1:0]    w_idle_next;
    logic             w_idle_done;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [1:0] b);
        logic [CNTW:0] s;
        s = {1'b0, a} + (CNTW + 1)'(b);
        return s[CNTW] ? '1 : s[CNTW-1:0];
    endfunction

    // No m_ready term here: the buffer only needs a free slot, which keeps the read port off the downstream path.
    assign w_rinc = rrst_n & ~fifo_rempty &
                    ((r_state == S_FLUSH) | (en & (r_count != 2'd2)));
    assign w_pop  = (r_count != 2'd0) & m_ready;

    assign w_idle_next = flush       ? '0 :
                         fifo_rempty ? r_idle + IW'(1) : '0;
    assign w_idle_done = (w_idle_next == IW'(FLUSH_IDLE));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state    <= S_RUN;
            r_count    <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_idle     <= '0;
            r_rd_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (flush) begin
                        // Everything buffered plus any word read this cycle is discarded.
                        r_state    <= S_FLUSH;
                        r_count    <= 2'd0;
                        r_idle     <= '0;
                        r_drop_cnt <= sat_add(r_drop_cnt, r_count + {1'b0, w_rinc});
                    end else begin
                        r_count  <= r_count + {1'b0, w_rinc} - {1'b0, w_pop};
                        r_rd_cnt <= r_rd_cnt + CNTW'(w_pop);
                        if (w_rinc && (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) begin
                            r_head <= fifo_rdata;
                        end else if (w_rinc) begin
                            r_tail <= fifo_rdata;
                        end else if (w_pop && r_count == 2'd2) begin
                            r_head <= r_tail;
                        end
                    end
                end
                S_FLUSH: begin
                    r_drop_cnt <= sat_add(r_drop_cnt, {1'b0, w_rinc});
                    r_idle     <= w_idle_done ? '0 : w_idle_next;
                    if (w_idle_done) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign fifo_rinc     = w_rinc;
    assign m_data        = r_head;
    assign m_valid       = (r_count != 2'd0);
    assign flushing      = (r_state == S_FLUSH);
    assign words_read    = r_rd_cnt;
    assign words_dropped = r_drop_cnt;

endmodule
